aes_subbytes_pipe: RTL and testbench

Parametrised, pipelined AES byte-substitution unit. It applies the FIPS-197 forward S-box or inverse S-box to LANES bytes in parallel: 4 lanes for SubWord in key expansion, 16 lanes for a full-state SubBytes/InvSubBytes. Operation is selectable per transfer. It sits between the AES round controller and ShiftRows/MixColumns, with valid/ready handshakes on both sides, full-throughput streaming and lossless backpressure.

---
 rtl/aes_subbytes_pipe.sv | 151 +++++++++++++++
 tb/tb_aes_subbytes_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes over LANES bytes with valid/ready on both sides.
// The GF(2^8) inverse is computed in logic; the lookup feeds stage 1 (or the only stage).
module aes_subbytes_pipe #(
    parameter int LANES  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_inv_i,
    input  logic [8*LANES-1:0] in_data_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [8*LANES-1:0] out_data_o,
    output logic [TAG_W-1:0]   out_tag_o,
    output logic               busy_o,
    output logic [15:0]        xfer_cnt_o
);
    localparam int DW = 8 * LANES;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] p;
        s = x;
        p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic inv, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] y;
        a = inv ? ({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05) : b;
        y = gf_inv(a);
        if (!inv)
            y = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
        return y;
    endfunction

    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0][DW-1:0]     data_q;
    logic [STAGES-1:0][TAG_W-1:0]  tag_q;
    logic [STAGES-1:0][DW-1:0]     src_data;
    logic [STAGES-1:0][TAG_W-1:0]  src_tag;
    logic [STAGES-1:0]             adv;
    logic [STAGES-1:0]             load;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          lk_inv;
    logic [DW-1:0]                 lk_in;
    logic [DW-1:0]                 lk_out;
    logic                          room;

    // A stage moves on when downstream has a hole anywhere below it or the sink takes the head
    always_comb begin
        adv  = '0;
        room = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            room = out_ready_i;
            for (int j = k + 1; j < STAGES; j++)
                room = room | ~vld_q[j];
            adv[k] = vld_q[k] & room;
        end
    end

    assign in_ready_o = ~vld_q[0] | adv[0];

    always_comb begin
        load    = '0;
        load[0] = in_valid_i & in_ready_o;
        for (int k = 1; k < STAGES; k++)
            load[k] = adv[k-1];
    end

    generate
        if (STAGES == 1) begin : g_lk_in
            assign lk_inv = in_inv_i;
            assign lk_in  = in_data_i;
        end else begin : g_lk_reg
            // Mode is only needed until the lookup; later stages carry substituted bytes
            logic inv0_q;
            always_ff @(posedge clk_i) begin
                if (rst_i)        inv0_q <= 1'b0;
                else if (load[0]) inv0_q <= in_inv_i;
            end
            assign lk_inv = inv0_q;
            assign lk_in  = data_q[0];
        end
    endgenerate

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lk_out[8*i +: 8] = sbox(lk_inv, lk_in[8*i +: 8]);
    end

    always_comb begin
        src_data    = '0;
        src_tag     = '0;
        src_data[0] = (STAGES == 1) ? lk_out : in_data_i;
        src_tag[0]  = in_tag_i;
        for (int k = 1; k < STAGES; k++) begin
            src_data[k] = (k == 1) ? lk_out : data_q[k-1];
            src_tag[k]  = tag_q[k-1];
        end
    end

    assign cnt_d = cnt_q + {15'd0, out_valid_o & out_ready_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
            tag_q  <= '0;
            cnt_q  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_q[k]  <= 1'b1;
                    data_q[k] <= src_data[k];
                    tag_q[k]  <= src_tag[k];
                end else if (adv[k]) begin
                    vld_q[k]  <= 1'b0;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign out_data_o  = data_q[STAGES-1];
    assign out_tag_o   = tag_q[STAGES-1];
    assign busy_o      = |vld_q;
    assign xfer_cnt_o  = cnt_q;
endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Directed bench for aes_subbytes_pipe: 16-lane/2-stage instance plus a 4-lane/1-stage
// instance streamed 65537 times against a FIPS-197 table model.
module tb_aes_subbytes_pipe;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [3:0]   in_tag, out_tag;
    logic [15:0]  xfer_cnt;
    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, busy4;
    logic [31:0]  in_data4, out_data4;
    logic [3:0]   in_tag4, out_tag4;
    logic [15:0]  xfer_cnt4;

    int n_chk = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    logic [7:0] sb [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    logic [7:0] isb [0:255];

    aes_subbytes_pipe #(.LANES(16), .STAGES(2), .TAG_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_inv_i(in_inv),
        .in_data_i(in_data), .in_tag_i(in_tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_tag_o(out_tag), .busy_o(busy), .xfer_cnt_o(xfer_cnt));

    aes_subbytes_pipe #(.LANES(4), .STAGES(1), .TAG_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_inv_i(in_inv4),
        .in_data_i(in_data4), .in_tag_i(in_tag4), .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .out_data_o(out_data4), .out_tag_o(out_tag4), .busy_o(busy4), .xfer_cnt_o(xfer_cnt4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] sbm(input logic inv, input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
        return r;
    endfunction

    // single transfer into an empty pipe with out_ready held high
    task automatic xfer1(input logic inv, input logic [127:0] d, input logic [3:0] tg,
                         output logic [127:0] r, output logic [3:0] rt);
        in_valid = 1'b1; in_inv = inv; in_data = d; in_tag = tg;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !out_valid; i++) step();
        chk("xfer_vld", 128'(out_valid), 128'(1));
        r  = out_data;
        rt = out_tag;
        step();
        exp_cnt++;
    endtask

    initial begin
        logic [127:0] d, f, g, r;
        logic [3:0]   ft, gt, rt;
        logic [35:0]  q4 [$];
        logic [35:0]  e4;
        logic [31:0]  d4;
        int k, e, acc, n_in, n_out, cyc;

        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0; in_tag4 = '0; out_ready4 = 1'b0;
        step(); step();
        chk("rst_ovld", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_cnt", 128'(xfer_cnt), 128'(0));
        chk("rst_data", out_data, 128'(0));
        chk("rst_tag", 128'(out_tag), 128'(0));
        chk("rst_rdy", 128'(in_ready), 128'(1));
        chk("rst_cnt4", 128'(xfer_cnt4), 128'(0));
        rst = 1'b0;

        // 1: forward on 00..0f with latency check
        in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'h5;
        in_data = 128'h0f0e0d0c0b0a09080706050403020100;
        step();
        in_valid = 1'b0;
        chk("t1_lat", 128'(out_valid), 128'(0));
        step();
        chk("t1_vld", 128'(out_valid), 128'(1));
        chk("t1_data", out_data, 128'h76abd7fe2b670130c56f6bf27b777c63);
        chk("t1_tag", 128'(out_tag), 128'(4'h5));
        step();
        exp_cnt = 1;
        chk("t1_empty", 128'(busy), 128'(0));
        chk("t1_cnt", 128'(xfer_cnt), 128'(exp_cnt));

        // 2: inverse vector, then 256-value round trip
        xfer1(1'b1, 128'h76abd7fe2b670130c56f6bf27c16ed63, 4'h9, r, rt);
        chk("t2_inv", r, 128'h0f0e0d0c0b0a09080706050401ff5300);
        chk("t2_tag", 128'(rt), 128'(4'h9));
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16*j + i);
            xfer1(1'b0, d, 4'(j), f, ft);
            chk("t2_fwd", f, sbm(1'b0, d));
            xfer1(1'b1, f, 4'(j + 1), g, gt);
            chk("t2_rt", g, d);
        end
        chk("t2_cnt", 128'(xfer_cnt), 128'(exp_cnt));

        // 3: alternating mode on 0x53, back to back
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8); in_inv = c[0]; in_data = {16{8'h53}}; in_tag = c[3:0];
            if (c < 8) chk("t3_rdy", 128'(in_ready), 128'(1));
            step();
            if (c >= 1 && c <= 8) begin
                chk("t3_vld", 128'(out_valid), 128'(1));
                chk("t3_data", out_data, ((c - 1) % 2 == 1) ? {16{8'h50}} : {16{8'hed}});
                chk("t3_tag", 128'(out_tag), 128'(4'(c - 1)));
            end
        end
        exp_cnt += 8;
        chk("t3_cnt", 128'(xfer_cnt), 128'(exp_cnt));

        // 4: backpressure fill, hold, release and drain
        out_ready = 1'b0; k = 0;
        for (int c = 0; c < 6; c++) begin
            acc = int'(in_ready);
            in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'(k);
            in_data = (acc != 0) ? {16{8'(k)}} : {$urandom, $urandom, $urandom, $urandom};
            step();
            if (acc != 0) k++;
            if (k == 2) chk("t4_hold", out_data, {16{8'h63}});
        end
        chk("t4_acc", 128'(k), 128'(2));
        chk("t4_nrdy", 128'(in_ready), 128'(0));
        chk("t4_htag", 128'(out_tag), 128'(0));
        out_ready = 1'b1;
        #1;
        chk("t4_rdy", 128'(in_ready), 128'(1));
        e = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (k < 4); in_data = {16{8'(k)}}; in_tag = 4'(k);
            #1;
            if (out_valid) begin
                if (e < 4) begin
                    chk("t4_ord", out_data, {16{sb[e]}});
                    chk("t4_otag", 128'(out_tag), 128'(4'(e)));
                end else begin
                    chk("t4_extra", 128'(out_valid), 128'(0));
                end
                e++;
            end
            acc = int'(in_valid && in_ready);
            step();
            if (acc != 0) k++;
        end
        exp_cnt += 4;
        chk("t4_nout", 128'(e), 128'(4));
        chk("t4_cnt", 128'(xfer_cnt), 128'(exp_cnt));
        chk("t4_idle", 128'(busy), 128'(0));

        // 5: reset with a full, stalled pipe
        out_ready = 1'b0; in_valid = 1'b1; in_data = {16{8'hAA}};
        step(); step(); step();
        chk("t5_full", 128'(busy), 128'(1));
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("t5_ovld", 128'(out_valid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_cnt", 128'(xfer_cnt), 128'(0));
        chk("t5_rdy", 128'(in_ready), 128'(1));
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_stale", 128'(out_valid), 128'(0));
        end

        // 6: 4 lanes, 1 stage, 65537 transfers with random backpressure
        n_in = 0; n_out = 0; cyc = 0;
        while (n_out < 65537 && cyc < 90000) begin
            out_ready4 = ($urandom_range(31, 0) != 0);
            in_valid4  = (n_in < 65537);
            in_inv4    = $urandom_range(1, 0) == 1;
            in_data4   = $urandom;
            in_tag4    = 4'(n_in);
            #1;
            if (out_valid4 && out_ready4) begin
                if (q4.size() > 0) begin
                    e4 = q4.pop_front();
                    chk("t6_data", 128'({out_tag4, out_data4}), 128'(e4));
                end else begin
                    chk("t6_spur", 128'(out_valid4), 128'(0));
                end
                n_out++;
            end
            if (in_valid4 && in_ready4) begin
                for (int i = 0; i < 4; i++)
                    d4[8*i +: 8] = in_inv4 ? isb[in_data4[8*i +: 8]] : sb[in_data4[8*i +: 8]];
                q4.push_back({in_tag4, d4});
                n_in++;
            end
            step();
            cyc++;
        end
        in_valid4 = 1'b0;
        chk("t6_done", 128'(n_out), 128'(65537));
        chk("t6_wrap", 128'(xfer_cnt4), 128'(16'h0001));
        chk("t6_idle", 128'(busy4), 128'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
